// File: rtl/uart_receive_rx.sv
// ----------------------------------------------------------------------------
// uart_receive_rx -- 8N1 UART receiver
//
// Receives asynchronous serial frames (start bit 0, 8 data bits LSB first,
// one stop bit 1, no parity) and presents each correctly framed byte.
//
// Parameters
//   CLK_FREQ  : CLK frequency in Hz
//   BAUD      : serial bit rate in bit/s; one bit lasts CLK_FREQ/BAUD clocks
//
// Ports
//   CLK       : system clock, rising edge
//   RST       : synchronous active-high reset
//   RXD       : asynchronous serial input, idle high
//   DATA      : last correctly received byte, held between frames
//   RXD_READY : one-clock pulse when DATA has just been updated
// ----------------------------------------------------------------------------
module uart_receive_rx #(
   parameter int unsigned CLK_FREQ = 27000000,
   parameter int unsigned BAUD     = 1000000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       RXD,
   output logic [7:0] DATA,
   output logic       RXD_READY
);

   localparam int unsigned DIV   = CLK_FREQ / BAUD;
   localparam int unsigned HALF  = DIV / 2;
   localparam int unsigned CNT_W = $clog2(DIV + 1);

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA_BITS,
      STOP
   } state_t;

   state_t           state, state_nx;
   logic             rxd_meta, rxd_sync;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [2:0]       idx, idx_nx;
   logic [7:0]       shift, shift_nx;
   logic [7:0]       data_nx;
   logic             ready_nx;
   logic             frame_err, frame_err_nx;

   always_ff @(posedge CLK) begin
      if (RST) begin
         rxd_meta  <= 1'b1;
         rxd_sync  <= 1'b1;
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         shift     <= '0;
         frame_err <= 1'b0;
         DATA      <= '0;
         RXD_READY <= 1'b0;
      end else begin
         rxd_meta  <= RXD;
         rxd_sync  <= rxd_meta;
         state     <= state_nx;
         cnt       <= cnt_nx;
         idx       <= idx_nx;
         shift     <= shift_nx;
         frame_err <= frame_err_nx;
         DATA      <= data_nx;
         RXD_READY <= ready_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      idx_nx       = idx;
      shift_nx     = shift;
      frame_err_nx = frame_err;
      data_nx      = DATA;
      ready_nx     = 1'b0;

      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (!rxd_sync) begin
               state_nx = START;
            end
         end

         // Re-check the line half a bit in; a high sample means the
         // falling edge was only a glitch.
         START: begin
            if (cnt == HALF_LAST) begin
               cnt_nx = '0;
               if (rxd_sync) begin
                  state_nx = IDLE;
               end else begin
                  state_nx = DATA_BITS;
                  idx_nx   = '0;
               end
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end

         DATA_BITS: begin
            if (cnt == BIT_LAST) begin
               cnt_nx        = '0;
               shift_nx[idx] = rxd_sync;
               if (idx == 3'd7) begin
                  state_nx = STOP;
               end else begin
                  idx_nx = idx + 1'b1;
               end
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end

         // A low stop sample sets frame_err; the FSM then parks here until
         // the line goes high so a stuck-low line cannot retrigger frames.
         STOP: begin
            if (frame_err) begin
               if (rxd_sync) begin
                  frame_err_nx = 1'b0;
                  state_nx     = IDLE;
               end
            end else if (cnt == BIT_LAST) begin
               cnt_nx = '0;
               if (rxd_sync) begin
                  data_nx  = shift;
                  ready_nx = 1'b1;
                  state_nx = IDLE;
               end else begin
                  frame_err_nx = 1'b1;
               end
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end

         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_receive_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_receive_rx -- directed self-checking bench for uart_receive_rx
//
// 27 MHz clock, 1 Mbaud line (27 clocks per bit). The serial line is driven
// on falling clock edges; a monitor on falling edges counts RXD_READY pulses,
// logs the byte seen with each pulse and flags any DATA change without one.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_receive_rx;

   localparam int DIV = 27;

   logic       clk;
   logic       rst;
   logic       rxd;
   logic [7:0] data;
   logic       rxd_ready;

   int checks   = 0;
   int failures = 0;

   int         cyc         = 0;
   int         pulses      = 0;
   int         pulse_cyc   = 0;
   int         data_glitch = 0;
   logic [7:0] prev_data   = 8'h00;
   logic [7:0] data_log[$];

   uart_receive_rx #(
      .CLK_FREQ (27000000),
      .BAUD     (1000000)
   ) dut (
      .CLK       (clk),
      .RST       (rst),
      .RXD       (rxd),
      .DATA      (data),
      .RXD_READY (rxd_ready)
   );

   initial clk = 1'b0;
   always #18.518 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst) begin
         prev_data = data;
      end else begin
         if (rxd_ready) begin
            pulses    = pulses + 1;
            pulse_cyc = cyc;
            data_log.push_back(data);
         end else if (data !== prev_data) begin
            data_glitch = data_glitch + 1;
         end
         prev_data = data;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      rxd = b;
      repeat (DIV) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop);
      rxd = 1'b1;
   endtask

   // Waits until the pulse count reaches target; a timeout is a failed check.
   task automatic wait_pulses(input string tag, input int target, input int budget);
      int n;
      n = 0;
      while (pulses < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_timeout"}, (pulses >= target) ? 32'd1 : 32'd0, 32'd1);
   endtask

   initial begin
      int p0;
      int start_cyc;
      int lat;

      rst = 1'b1;
      rxd = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      idle(10);

      // Reset state
      check("rst_data", data, 8'h00);
      check("rst_ready", rxd_ready, 1'b0);
      check("rst_pulses", pulses, 0);

      // 0xAA, with start-to-pulse latency
      p0        = pulses;
      start_cyc = cyc;
      send_frame(8'hAA, 1'b1);
      wait_pulses("aa", p0 + 1, 60);
      lat = pulse_cyc - start_cyc;
      check("aa_latency_in_257_259", (lat >= 257 && lat <= 259) ? 32'd1 : 32'd0, 32'd1);
      idle(20);
      check("aa_pulse_count", pulses - p0, 1);
      check("aa_data", data, 8'hAA);

      // 5 us idle, then 0x54
      idle(135);
      check("aa_hold", data, 8'hAA);
      p0 = pulses;
      send_frame(8'h54, 1'b1);
      wait_pulses("54", p0 + 1, 60);
      idle(20);
      check("54_pulse_count", pulses - p0, 1);
      check("54_data", data, 8'h54);

      // ~200 ns low glitch
      p0 = pulses;
      rxd = 1'b0;
      idle(5);
      rxd = 1'b1;
      idle(60);
      check("glitch_pulses", pulses - p0, 0);
      check("glitch_data", data, 8'h54);

      // Framing error, then 0x3C
      p0 = pulses;
      send_frame(8'h12, 1'b0);
      idle(60);
      check("ferr_pulses", pulses - p0, 0);
      check("ferr_data", data, 8'h54);
      send_frame(8'h3C, 1'b1);
      wait_pulses("3c", p0 + 1, 60);
      idle(20);
      check("3c_pulse_count", pulses - p0, 1);
      check("3c_data", data, 8'h3C);

      // Back-to-back frames
      p0 = pulses;
      data_log.delete();
      send_frame(8'h81, 1'b1);
      send_frame(8'h7E, 1'b1);
      wait_pulses("b2b", p0 + 2, 60);
      idle(20);
      check("b2b_pulse_count", pulses - p0, 2);
      check("b2b_first", (data_log.size() > 0) ? data_log[0] : 8'hxx, 8'h81);
      check("b2b_second", (data_log.size() > 1) ? data_log[1] : 8'hxx, 8'h7E);

      // Line stuck low for over two frame times
      p0 = pulses;
      rxd = 1'b0;
      idle(600);
      check("stuck_low_pulses", pulses - p0, 0);
      rxd = 1'b1;
      idle(60);
      check("stuck_low_data", data, 8'h7E);
      send_frame(8'hA5, 1'b1);
      wait_pulses("a5", p0 + 1, 60);
      idle(20);
      check("a5_data", data, 8'hA5);

      // Reset in the middle of data bit 4 of 0xF0; the rest of the line is high
      p0 = pulses;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      rxd = 1'b1;
      idle(10);
      rst = 1'b1;
      idle(3);
      rst = 1'b0;
      idle(DIV - 13);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      idle(60);
      check("abort_pulses", pulses - p0, 0);
      check("abort_data_reset", data, 8'h00);
      send_frame(8'hFF, 1'b1);
      wait_pulses("ff", p0 + 1, 60);
      idle(20);
      check("ff_pulse_count", pulses - p0, 1);
      check("ff_data", data, 8'hFF);

      check("data_only_with_pulse", data_glitch, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
